// File: rtl/mem_seq.sv
// mem_seq: sequenced single-port byte RAM with its own address register.
// Accepts one read or write per IDLE visit, inserts WAIT wait states, and
// completes with a one-cycle ack. Read data is driven onto the shared bus
// only during that ack cycle.
module mem_seq #(
  parameter int AW   = 11,
  parameter int WAIT = 2
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic [15:0]   WBUS,
  input  logic          nLm,
  inout  wire  [7:0]    data,
  input  logic          req,
  input  logic          we,
  output logic          busy,
  output logic          ack,
  output logic [AW-1:0] mar_q
);

  localparam int DATA_W = 8;
  localparam logic [2:0] WAIT_L = 3'(WAIT);

  typedef enum logic [1:0] {IDLE, WAITS, ACCESS, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              start;

  logic [AW-1:0]     op_addr;
  logic              op_we;
  logic [DATA_W-1:0] op_wdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] mem [2**AW];

  // Upper WBUS bits are not part of the address.
  logic unused_wbus;
  assign unused_wbus = ^WBUS;

  assign start = (state == IDLE) && req;

  // Control state, wait counter and address register.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= IDLE;
      cnt   <= '0;
      mar_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!nLm) mar_q <= WBUS[AW-1:0];
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = (state != IDLE);
    ack       = (state == DONE);
    unique case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_L != 3'd0) begin
            state_nxt = WAITS;
            cnt_nxt   = WAIT_L;
          end else begin
            state_nxt = ACCESS;
          end
        end
      end
      WAITS: begin
        cnt_nxt = cnt - 3'd1;
        // cnt==0 cannot occur here; treated like 1 so the FSM never sticks.
        if (cnt <= 3'd1) state_nxt = ACCESS;
      end
      ACCESS: state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture at the accepting edge; the access uses only these copies.
  always_ff @(posedge CLK) begin
    if (start) begin
      op_addr  <= mar_q;
      op_we    <= we;
      op_wdata <= data;
    end
  end

  // RAM access on the edge leaving ACCESS; a reset at that edge cancels it.
  always_ff @(posedge CLK) begin
    if (state == ACCESS && !CLR) begin
      if (op_we) mem[op_addr] <= op_wdata;
      else       rdata        <= mem[op_addr];
    end
  end

  // Bus is driven only in DONE of a read, when the MDR is listening.
  assign data = (state == DONE && !op_we) ? rdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: two instances (WAIT=2 and WAIT=0) share stimulus; a
// transaction-level model predicts busy/ack/mar_q/data every cycle.
module tb_mem_seq;
  localparam int AW = 11;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        CLR;
  logic [15:0] WBUS;
  logic        nLm, req, we;
  logic        drv_on;
  logic [7:0]  drv_val;
  wire  [7:0]  data0, data1;
  logic        busy0, busy1, ack0, ack1;
  logic [AW-1:0] mar0, mar1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: t = edges elapsed since the accepting edge (0 = idle).
  int          t     [2];
  logic [AW-1:0] mmar [2];
  logic [AW-1:0] oaddr[2];
  logic        owe   [2];
  logic [7:0]  owd   [2];
  logic [7:0]  rd    [2];
  bit          rdk   [2];
  logic [7:0]  mem   [2][2048];
  bit          known [2][2048];

  logic        s_req, s_we, s_nLm;
  logic [15:0] s_wbus;
  logic [7:0]  s_data [2];
  logic        s_drv;

  function automatic int wv(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  logic rd_done0, rd_done1;
  assign rd_done0 = (t[0] == 4) && !owe[0];
  assign rd_done1 = (t[1] == 2) && !owe[1];
  assign data0 = (drv_on && !rd_done0) ? drv_val : 8'hzz;
  assign data1 = (drv_on && !rd_done1) ? drv_val : 8'hzz;

  mem_seq #(.AW(AW), .WAIT(2)) u0 (
    .CLK(CLK), .CLR(CLR), .WBUS(WBUS), .nLm(nLm), .data(data0),
    .req(req), .we(we), .busy(busy0), .ack(ack0), .mar_q(mar0));
  mem_seq #(.AW(AW), .WAIT(0)) u1 (
    .CLK(CLK), .CLR(CLR), .WBUS(WBUS), .nLm(nLm), .data(data1),
    .req(req), .we(we), .busy(busy1), .ack(ack1), .mar_q(mar1));

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // A released bus reads as Z in four-state tools and as 0 in two-state ones.
  task automatic chk_rel(input string nm, input logic [7:0] v);
    n_cmp++;
    if (!(v === 8'hzz || v === 8'h00)) begin
      n_bad++;
      $display("FAIL %s: bus driven with %0h, expected released (t=%0t)", nm, v, $time);
    end
  endtask

  task automatic model_edge(input int i);
    if (t[i] > 0) begin
      t[i]++;
      if (t[i] == wv(i) + 2) begin
        if (owe[i]) begin
          mem[i][oaddr[i]]   = owd[i];
          known[i][oaddr[i]] = 1'b1;
        end else begin
          rd[i]  = mem[i][oaddr[i]];
          rdk[i] = known[i][oaddr[i]];
        end
      end else if (t[i] == wv(i) + 3) begin
        t[i] = 0;
      end
    end else if (s_req) begin
      t[i]     = 1;
      oaddr[i] = mmar[i];
      owe[i]   = s_we;
      owd[i]   = s_data[i];
    end
    if (!s_nLm) mmar[i] = s_wbus[AW-1:0];
  endtask

  // Model update on each clock edge, or immediately on reset.
  initial begin
    for (int i = 0; i < 2; i++) begin
      t[i] = 0; mmar[i] = '0; owe[i] = 1'b1; rdk[i] = 1'b0;
      for (int a = 0; a < 2048; a++) known[i][a] = 1'b0;
    end
    forever begin
      @(posedge CLK or posedge CLR);
      if (CLR) begin
        for (int i = 0; i < 2; i++) begin t[i] = 0; mmar[i] = '0; end
      end else begin
        model_edge(0);
        model_edge(1);
      end
    end
  end

  task automatic cmp_inst(input int i, input logic b, input logic a,
                          input logic [AW-1:0] m, input logic [7:0] d);
    chk($sformatf("busy%0d", i), int'(b), int'(t[i] != 0));
    chk($sformatf("ack%0d", i), int'(a), int'(t[i] == wv(i) + 2));
    chk($sformatf("mar%0d", i), int'(m), int'(mmar[i]));
    if (t[i] == wv(i) + 2 && !owe[i]) begin
      if (rdk[i]) chk($sformatf("rdata%0d", i), int'(d), int'(rd[i]));
    end else if (!s_drv) begin
      chk_rel($sformatf("release%0d", i), d);
    end
  endtask

  // Compare on the falling edge, then capture inputs for the next rising edge.
  initial begin
    forever begin
      @(negedge CLK);
      s_drv = drv_on;
      cmp_inst(0, busy0, ack0, mar0, data0);
      cmp_inst(1, busy1, ack1, mar1, data1);
      s_req = req; s_we = we; s_nLm = nLm; s_wbus = WBUS;
      s_data[0] = data0; s_data[1] = data1;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    req = 1'b0; we = 1'b0; nLm = 1'b1; drv_on = 1'b0;
  endtask

  task automatic load_mar(input logic [AW-1:0] a);
    nLm = 1'b0; WBUS = {5'b0, a};
    step();
    nLm = 1'b1;
  endtask

  task automatic wait_idle(output int acks0);
    int k;
    acks0 = 0;
    for (k = 0; k < 40; k++) begin
      if (!busy0 && !busy1) break;
      if (ack0) acks0++;
      step();
    end
    if (k == 40) chk("idle_timeout", 0, 1);
  endtask

  task automatic access(input int sel, input logic w, input logic [7:0] wd,
                        output int lat, output int bcnt, output logic [7:0] rdv);
    int e, dummy;
    logic b, a;
    req = 1'b1; we = w; drv_on = w; drv_val = wd;
    step();
    req = 1'b0; we = 1'b0; drv_on = 1'b0;
    lat = -1; bcnt = 0; rdv = 8'h00;
    for (e = 0; e < 40; e++) begin
      b = sel ? busy1 : busy0;
      a = sel ? ack1 : ack0;
      if (a && lat < 0) begin lat = e; rdv = sel ? data1 : data0; end
      if (!b) break;
      bcnt++;
      step();
    end
    if (e == 40) chk("access_timeout", 0, 1);
    wait_idle(dummy);
  endtask

  initial begin
    int lat, bc, acks;
    logic [7:0] rv;
    CLR = 1'b1; WBUS = '0; drv_val = '0;
    idle_inputs();
    repeat (2) @(posedge CLK);
    #1 CLR = 1'b0;

    // Reset asserted mid-cycle while a read is in WAITS.
    load_mar(11'h155);
    req = 1'b1; step(); req = 1'b0;
    #1 CLR = 1'b1;
    #1;
    chk("rst_busy", int'(busy0), 0);
    chk("rst_ack", int'(ack0), 0);
    chk("rst_mar", int'(mar0), 0);
    chk_rel("rst_data", data0);
    #1 CLR = 1'b0;
    step();

    // WAIT=2 write then read of 0x123.
    load_mar(11'h123);
    access(0, 1'b1, 8'h5A, lat, bc, rv);
    chk("w2_wr_lat", lat, 3);
    chk("w2_busy_cycles", bc, 4);
    access(0, 1'b0, 8'h00, lat, bc, rv);
    chk("w2_rd_lat", lat, 3);
    chk("w2_rd_data", int'(rv), 8'h5A);

    // WAIT=0 write then read of 0x7FF.
    load_mar(11'h7FF);
    access(1, 1'b1, 8'hC3, lat, bc, rv);
    chk("w0_wr_lat", lat, 1);
    chk("w0_busy_cycles", bc, 2);
    access(1, 1'b0, 8'h00, lat, bc, rv);
    chk("w0_rd_data", int'(rv), 8'hC3);

    // req held high; write attempt in WAITS is ignored.
    load_mar(11'h010);
    access(0, 1'b1, 8'h3C, lat, bc, rv);
    req = 1'b1; we = 1'b0;
    step();
    acks = 0;
    for (int e = 0; e <= 4; e++) begin
      if (ack0) acks++;
      if (e == 0) begin we = 1'b1; drv_on = 1'b1; drv_val = 8'hFF; end
      if (e == 2) begin we = 1'b0; drv_on = 1'b0; end
      if (e == 4) chk("held_idle_gap", int'(busy0), 0);
      step();
    end
    chk("held_restart", int'(busy0), 1);
    req = 1'b0;
    chk("held_one_ack", acks, 1);
    wait_idle(acks);
    access(0, 1'b0, 8'h00, lat, bc, rv);
    chk("held_mem_kept", int'(rv), 8'h3C);

    // Operands latched at the request edge.
    load_mar(11'h030);
    access(0, 1'b1, 8'h77, lat, bc, rv);
    load_mar(11'h020);
    req = 1'b1; we = 1'b1; drv_on = 1'b1; drv_val = 8'h11;
    step();
    req = 1'b0; we = 1'b0; nLm = 1'b0; WBUS = 16'h0030; drv_val = 8'h22;
    step();
    nLm = 1'b1; drv_on = 1'b0;
    wait_idle(acks);
    chk("latch_ack", acks, 1);
    chk("latch_mar", int'(mar0), 11'h030);
    access(0, 1'b0, 8'h00, lat, bc, rv);
    chk("latch_030", int'(rv), 8'h77);
    load_mar(11'h020);
    access(0, 1'b0, 8'h00, lat, bc, rv);
    chk("latch_020", int'(rv), 8'h11);

    // Reset during WAITS of a write cancels it.
    load_mar(11'h040);
    access(0, 1'b1, 8'hAA, lat, bc, rv);
    req = 1'b1; we = 1'b1; drv_on = 1'b1; drv_val = 8'h55;
    step();
    req = 1'b0; we = 1'b0; drv_on = 1'b0;
    #1 CLR = 1'b1;
    #1 CLR = 1'b0;
    acks = 0;
    for (int e = 0; e < 6; e++) begin
      step();
      if (ack0) acks++;
    end
    chk("rstw_no_ack", acks, 0);
    load_mar(11'h040);
    access(0, 1'b0, 8'h00, lat, bc, rv);
    chk("rstw_kept", int'(rv), 8'hAA);

    // Randomized traffic over a small address pool.
    for (int n = 0; n < 800; n++) begin
      req     = ($urandom_range(0, 2) == 0);
      we      = 1'($urandom_range(0, 1));
      nLm     = ($urandom_range(0, 3) != 0);
      WBUS    = {5'($urandom), 11'(11'h100 + $urandom_range(0, 7))};
      drv_on  = 1'($urandom_range(0, 1));
      drv_val = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #1 CLR = 1'b1;
        #1 CLR = 1'b0;
      end
      step();
    end
    idle_inputs();
    wait_idle(acks);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
